// File: rtl/lab3_cache_flush_pkg.sv
// Shared definitions for the cache flush controller: FSM state encoding
// and the address field widths used to rebuild a line address from
// {tag, index, word, byte offset}.
package lab3_cache_flush_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHK,
    WB_REQ,
    WB_RESP,
    CLR,
    DONE
  } flush_state_e;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int OPAQUE_W   = 8;
  localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/mem_msg_pkg.sv
// Memory message types shared by the cache and the memory port.
// A 4-byte request carries type, opaque tag, address, length and data;
// a response echoes type and opaque with test bits, length and read data.
// len = 0 encodes a full 4-byte transfer.
package mem_msg_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/lab3_cache_flush_ctrl.sv
// Full-cache flush sequencer for the direct-mapped write-back cache.
// Walks every line index, reads valid/dirty/tag, writes back each dirty
// line one word at a time over the memory port, then clears the line.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   flush               flush request (only looked at while idle)
//   flush_done          one-cycle pulse at the end of a flush
//   busy                high whenever a flush is in progress
//   arr_idx             line index for tag/data array access
//   arr_rd_en           tag array read (result valid next cycle)
//   arr_valid/dirty/tag tag array read data
//   data_word           word select into the combinational data array read
//   data_rdata          selected data word
//   arr_clr_en          clear valid+dirty of line arr_idx at the clock edge
//   cache_req_*         write-back request port (val/rdy/msg)
//   cache_resp_*        write-back response port (val/rdy/msg)
//   wb_err              sticky flag for a malformed write-back response
module lab3_cache_flush_ctrl
  import mem_msg_pkg::*;
  import lab3_cache_flush_pkg::*;
#(
  parameter  int NUM_LINES      = 16,
  parameter  int WORDS_PER_LINE = 4,
  localparam int IDX_W          = $clog2(NUM_LINES),
  localparam int WRD_W          = $clog2(WORDS_PER_LINE),
  localparam int TAG_W          = ADDR_W - IDX_W - WRD_W - BYTE_OFF_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  output logic [IDX_W-1:0]   arr_idx,
  output logic               arr_rd_en,
  input  logic               arr_valid,
  input  logic               arr_dirty,
  input  logic [TAG_W-1:0]   arr_tag,
  output logic [WRD_W-1:0]   data_word,
  input  logic [DATA_W-1:0]  data_rdata,
  output logic               arr_clr_en,
  output logic               cache_req_val,
  input  logic               cache_req_rdy,
  output mem_req_4B_t        cache_req_msg,
  input  logic               cache_resp_val,
  output logic               cache_resp_rdy,
  input  mem_resp_4B_t       cache_resp_msg,
  output logic               wb_err
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LINES - 1);
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(WORDS_PER_LINE - 1);

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WRD_W-1:0]  word_q, word_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              wb_err_q, wb_err_d;

  // Only opaque and type are inspected on a write-back response.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{cache_resp_msg.test, cache_resp_msg.len,
                              cache_resp_msg.data};

  // State, counters and the latched tag; reset abandons any flush in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      tag_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      wb_err_q <= wb_err_d;
    end
  end

  // Next-state and control outputs. Clean or invalid lines skip straight
  // to CLR so every line is left invalid at the end of the walk.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    word_d         = word_q;
    tag_d          = tag_q;
    wb_err_d       = wb_err_q;
    flush_done     = 1'b0;
    busy           = 1'b1;
    arr_rd_en      = 1'b0;
    arr_clr_en     = 1'b0;
    cache_req_val  = 1'b0;
    cache_resp_rdy = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (flush) begin
          state_d = RD;
          idx_d   = '0;
          word_d  = '0;
        end
      end

      RD: begin
        arr_rd_en = 1'b1;
        state_d   = CHK;
      end

      CHK: begin
        if (arr_valid && arr_dirty) begin
          tag_d   = arr_tag;
          word_d  = '0;
          state_d = WB_REQ;
        end else begin
          state_d = CLR;
        end
      end

      WB_REQ: begin
        cache_req_val = 1'b1;
        if (cache_req_rdy) begin
          state_d = WB_RESP;
        end
      end

      // A bad response is only flagged; the walk carries on regardless.
      WB_RESP: begin
        cache_resp_rdy = 1'b1;
        if (cache_resp_val) begin
          if ((cache_resp_msg.type_ != MEM_TYPE_WRITE) ||
              (cache_resp_msg.opaque != OPAQUE_W'(word_q))) begin
            wb_err_d = 1'b1;
          end
          if (word_q == LAST_WORD) begin
            state_d = CLR;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = WB_REQ;
          end
        end
      end

      CLR: begin
        arr_clr_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end

      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The request message is built purely from registered state and the
  // combinational data read, so it holds steady while the port stalls.
  always_comb begin
    cache_req_msg        = '0;
    cache_req_msg.type_  = MEM_TYPE_WRITE;
    cache_req_msg.opaque = OPAQUE_W'(word_q);
    cache_req_msg.addr   = {tag_q, idx_q, word_q, {BYTE_OFF_W{1'b0}}};
    cache_req_msg.len    = 2'd0;
    cache_req_msg.data   = data_rdata;
  end

  assign arr_idx   = idx_q;
  assign data_word = word_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_lab3_cache_flush_ctrl.sv
// Self-checking bench for lab3_cache_flush_ctrl (16 lines x 4 words).
// Models the tag/data arrays and a memory that answers each write-back
// one cycle after acceptance, with optional request stalls and a
// corrupted response opaque.
module tb_lab3_cache_flush_ctrl;
  import mem_msg_pkg::*;

  localparam int NL = 16;
  localparam int NW = 4;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         flush_done;
  logic         busy;
  logic [3:0]   arr_idx;
  logic         arr_rd_en;
  logic         arr_valid;
  logic         arr_dirty;
  logic [23:0]  arr_tag;
  logic [1:0]   data_word;
  logic [31:0]  data_rdata;
  logic         arr_clr_en;
  logic         cache_req_val;
  logic         cache_req_rdy;
  mem_req_4B_t  cache_req_msg;
  logic         cache_resp_val;
  logic         cache_resp_rdy;
  mem_resp_4B_t cache_resp_msg;
  logic         wb_err;

  lab3_cache_flush_ctrl #(.NUM_LINES(NL), .WORDS_PER_LINE(NW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .flush_done     (flush_done),
    .busy           (busy),
    .arr_idx        (arr_idx),
    .arr_rd_en      (arr_rd_en),
    .arr_valid      (arr_valid),
    .arr_dirty      (arr_dirty),
    .arr_tag        (arr_tag),
    .data_word      (data_word),
    .data_rdata     (data_rdata),
    .arr_clr_en     (arr_clr_en),
    .cache_req_val  (cache_req_val),
    .cache_req_rdy  (cache_req_rdy),
    .cache_req_msg  (cache_req_msg),
    .cache_resp_val (cache_resp_val),
    .cache_resp_rdy (cache_resp_rdy),
    .cache_resp_msg (cache_resp_msg),
    .wb_err         (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Array model
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [23:0] m_tag   [NL];
  logic [31:0] m_data  [NL][NW];

  assign data_rdata = m_data[arr_idx][data_word];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  opaque;
    logic [2:0]  typ;
    logic [1:0]  len;
  } req_rec_t;

  req_rec_t req_log[$];
  int       clr_log[$];

  // Memory / responder knobs
  int          stall_op = -1;
  int          stall_left = 0;
  bit          stall_started = 1'b0;
  mem_req_4B_t stall_msg;
  int          corrupt_op = -1;
  logic [7:0]  corrupt_val = 8'd0;
  bit          resp_pend = 1'b0;
  bit          resp_active = 1'b0;
  logic [7:0]  pend_opaque = 8'd0;

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Array, clear and memory-port model, all evaluated on the falling edge
  initial begin
    cache_req_rdy  = 1'b1;
    cache_resp_val = 1'b0;
    cache_resp_msg = '0;
    arr_valid      = 1'b0;
    arr_dirty      = 1'b0;
    arr_tag        = '0;
    forever begin
      @(negedge clk);
      if (arr_rd_en) begin
        arr_valid = m_valid[arr_idx];
        arr_dirty = m_dirty[arr_idx];
        arr_tag   = m_tag[arr_idx];
      end
      if (arr_clr_en) begin
        m_valid[arr_idx] = 1'b0;
        m_dirty[arr_idx] = 1'b0;
        clr_log.push_back(int'(arr_idx));
      end
      if (resp_active) begin
        cache_resp_val = 1'b0;
        resp_active    = 1'b0;
      end
      if (resp_pend) begin
        cache_resp_val       = 1'b1;
        cache_resp_msg       = '0;
        cache_resp_msg.type_ = MEM_TYPE_WRITE;
        cache_resp_msg.opaque = (int'(pend_opaque) == corrupt_op) ? corrupt_val : pend_opaque;
        resp_pend            = 1'b0;
        resp_active          = 1'b1;
      end
      if (cache_req_val && stall_left > 0 && int'(cache_req_msg.opaque) == stall_op) begin
        cache_req_rdy = 1'b0;
        if (!stall_started) begin
          stall_msg     = cache_req_msg;
          stall_started = 1'b1;
        end else begin
          check_output("stall_msg_stable", 128'(cache_req_msg), 128'(stall_msg));
        end
        stall_left--;
      end else begin
        cache_req_rdy = 1'b1;
      end
      if (cache_req_val && cache_req_rdy) begin
        req_log.push_back('{cache_req_msg.addr, cache_req_msg.data,
                            cache_req_msg.opaque, cache_req_msg.type_,
                            cache_req_msg.len});
        resp_pend   = 1'b1;
        pend_opaque = cache_req_msg.opaque;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_model();
    for (int l = 0; l < NL; l++) begin
      m_valid[l] = 1'b0;
      m_dirty[l] = 1'b0;
      m_tag[l]   = '0;
      for (int w = 0; w < NW; w++) m_data[l][w] = (w + 1) * 32'h11;
    end
    req_log.delete();
    clr_log.delete();
  endtask

  // Raises flush for one cycle (called at a falling edge while idle) and
  // returns the number of cycles from the sampling edge to flush_done.
  // A second flush pulse can be dropped in at cycle pulse_at.
  task automatic apply_stimulus(input int pulse_at, output int lat);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      flush = (n == pulse_at);
      if (flush_done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  task automatic check_clears(input string name);
    bit ok;
    ok = (clr_log.size() == NL);
    for (int i = 0; i < clr_log.size() && i < NL; i++)
      if (clr_log[i] != i) ok = 1'b0;
    check_output(name, 128'(ok), 128'(1));
  endtask

  task automatic check_all_invalid(input string name);
    int cnt;
    cnt = 0;
    for (int l = 0; l < NL; l++) if (m_valid[l]) cnt++;
    check_output(name, 128'(cnt), 128'(0));
  endtask

  typedef struct {
    int          line;
    bit          valid;
    bit          dirty;
    logic [23:0] tag;
    int          pulse_at;
    int          exp_reqs;
    int          exp_lat;
    logic [31:0] exp_addr0;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int found;
    int dones;

    vecs[0] = '{0,  1'b0, 1'b0, 24'h000000, 10, 0, 49, 32'h0000_0000};
    vecs[1] = '{5,  1'b1, 1'b1, 24'h000ABC, 0,  4, 57, 32'h000A_BC50};
    vecs[2] = '{3,  1'b1, 1'b0, 24'h000123, 0,  0, 49, 32'h0000_0000};
    vecs[3] = '{15, 1'b1, 1'b1, 24'hFFFFFF, 0,  4, 57, 32'hFFFF_FFF0};
    vecs[4] = '{0,  1'b0, 1'b1, 24'h000005, 0,  0, 49, 32'h0000_0000};

    reset = 1'b0;
    flush = 1'b0;
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_flush_done", 128'(flush_done), 128'(0));
    check_output("rst_busy", 128'(busy), 128'(0));
    check_output("rst_arr_rd_en", 128'(arr_rd_en), 128'(0));
    check_output("rst_arr_clr_en", 128'(arr_clr_en), 128'(0));
    check_output("rst_req_val", 128'(cache_req_val), 128'(0));
    check_output("rst_resp_rdy", 128'(cache_resp_rdy), 128'(0));
    check_output("rst_wb_err", 128'(wb_err), 128'(0));
    check_output("rst_idx", 128'(arr_idx), 128'(0));
    check_output("rst_word", 128'(data_word), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single-line flushes
    for (int v = 0; v < 5; v++) begin
      clear_model();
      m_valid[vecs[v].line] = vecs[v].valid;
      m_dirty[vecs[v].line] = vecs[v].dirty;
      m_tag[vecs[v].line]   = vecs[v].tag;
      apply_stimulus(vecs[v].pulse_at, lat);
      check_output($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
      repeat (3) @(negedge clk);
      check_output($sformatf("v%0d_idle_after", v), 128'(busy), 128'(0));
      check_output($sformatf("v%0d_req_count", v), 128'(req_log.size()), 128'(vecs[v].exp_reqs));
      if (vecs[v].exp_reqs > 0 && req_log.size() > 0)
        check_output($sformatf("v%0d_addr0", v), 128'(req_log[0].addr), 128'(vecs[v].exp_addr0));
      for (int i = 0; i < req_log.size() && i < vecs[v].exp_reqs; i++) begin
        check_output($sformatf("v%0d_r%0d_addr", v, i), 128'(req_log[i].addr),
                     128'({vecs[v].tag, 4'(vecs[v].line), 2'(i), 2'b00}));
        check_output($sformatf("v%0d_r%0d_data", v, i), 128'(req_log[i].data),
                     128'((i + 1) * 32'h11));
        check_output($sformatf("v%0d_r%0d_opaque", v, i), 128'(req_log[i].opaque), 128'(i));
        check_output($sformatf("v%0d_r%0d_type", v, i), 128'(req_log[i].typ), 128'(MEM_TYPE_WRITE));
        check_output($sformatf("v%0d_r%0d_len", v, i), 128'(req_log[i].len), 128'(0));
      end
      check_clears($sformatf("v%0d_clear_order", v));
      check_all_invalid($sformatf("v%0d_all_invalid", v));
    end

    // Request stalled for 7 cycles on word 2 of line 7
    clear_model();
    m_valid[7] = 1'b1;
    m_dirty[7] = 1'b1;
    m_tag[7]   = 24'h3C3C3C;
    stall_op = 2;
    stall_left = 7;
    stall_started = 1'b0;
    apply_stimulus(0, lat);
    check_output("stall_latency", 128'(lat), 128'(64));
    check_output("stall_consumed", 128'(stall_left), 128'(0));
    check_output("stall_req_count", 128'(req_log.size()), 128'(4));
    if (req_log.size() > 2)
      check_output("stall_w2_addr", 128'(req_log[2].addr), 128'(32'h3C3C_3C78));
    check_clears("stall_clear_order");
    stall_op = -1;
    repeat (2) @(negedge clk);

    // Reset while waiting for the response of line 9
    clear_model();
    m_valid[2] = 1'b1;
    m_valid[9] = 1'b1;
    m_dirty[9] = 1'b1;
    m_tag[9]   = 24'h000999;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (cache_resp_rdy && arr_idx == 4'd9) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_output("midrst_reached_line9", 128'(found), 128'(1));
    reset = 1'b0;
    @(negedge clk);
    check_output("midrst_busy", 128'(busy), 128'(0));
    check_output("midrst_req_val", 128'(cache_req_val), 128'(0));
    check_output("midrst_resp_rdy", 128'(cache_resp_rdy), 128'(0));
    check_output("midrst_clr_en", 128'(arr_clr_en), 128'(0));
    check_output("midrst_idx", 128'(arr_idx), 128'(0));
    reset = 1'b1;
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (flush_done) dones++;
    end
    check_output("midrst_no_done", 128'(dones), 128'(0));
    check_output("midrst_line2_cleared", 128'(m_valid[2]), 128'(0));
    check_output("midrst_line9_kept", 128'(m_valid[9]), 128'(1));
    req_log.delete();
    clr_log.delete();
    apply_stimulus(0, lat);
    check_output("restart_latency", 128'(lat), 128'(57));
    check_output("restart_req_count", 128'(req_log.size()), 128'(4));
    if (req_log.size() > 0)
      check_output("restart_addr0", 128'(req_log[0].addr), 128'(32'h0009_9990));
    check_clears("restart_clear_order");
    repeat (2) @(negedge clk);

    // Response carrying the wrong opaque on word 1
    clear_model();
    m_valid[2] = 1'b1;
    m_dirty[2] = 1'b1;
    m_tag[2]   = 24'h00F00D;
    corrupt_op  = 1;
    corrupt_val = 8'd2;
    check_output("err_before", 128'(wb_err), 128'(0));
    apply_stimulus(0, lat);
    check_output("err_latency", 128'(lat), 128'(57));
    check_output("err_set", 128'(wb_err), 128'(1));
    corrupt_op = -1;
    repeat (2) @(negedge clk);
    clear_model();
    apply_stimulus(0, lat);
    check_output("err_clean_latency", 128'(lat), 128'(49));
    check_output("err_sticky", 128'(wb_err), 128'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("err_cleared_by_reset", 128'(wb_err), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // flush held high through DONE restarts right after IDLE
    clear_model();
    flush = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (flush_done) begin
        lat = n;
        break;
      end
    end
    check_output("held_latency", 128'(lat), 128'(49));
    @(negedge clk);
    check_output("held_idle_gap", 128'(busy), 128'(0));
    @(negedge clk);
    check_output("held_restart_rd", 128'(arr_rd_en), 128'(1));
    check_output("held_restart_idx", 128'(arr_idx), 128'(0));
    flush = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (flush_done) begin
        found = 1;
        break;
      end
    end
    check_output("held_second_done", 128'(found), 128'(1));
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
